// File: rtl/alu_lcd_formatter.sv
// alu_lcd_formatter
// -----------------
// Downstream stage of the 4-bit ALU challenge unit. A debounced press of the
// push button captures the ALU operands, opcode and result. Each 4-bit value
// is converted to two decimal digits with a serial shift-add-3 (double
// dabble). The results drive the 12 ASCII character inputs of the board LCD
// controller.
//   Line 0 : "AA?BB="   (operand a, op char, operand b)
//   Line 1 : "R=sRR "   (sign char, result magnitude)
//
// Optional feature macro: SIGNED_RES_EN
//   When defined, a subtraction whose result has bit 3 set is shown as a
//   negative two's-complement value ("R=-02 "). When undefined, the sign
//   column is always a space and the result is shown unsigned (0..15).
//
// Parameters
//   DEB_CYCLES : consecutive stable cycles needed to accept a key level
//                change (>= 2)
//
// Ports
//   iCLK          in   system clock
//   iRST_N        in   asynchronous active-low reset
//   iKEY_N        in   raw push button, active-low, asynchronous to iCLK
//   iA, iB        in   4-bit ALU operands
//   iSEL          in   ALU opcode: 00 add, 01 sub, 10 and, 11 or
//   iRES          in   4-bit ALU result
//   d0x0..d0x5    out  LCD line 0 characters (ASCII)
//   d1x0..d1x5    out  LCD line 1 characters (ASCII)
//   oBUSY         out  high from the capture cycle through the conversion
//   oDONE         out  one-cycle pulse while freshly written characters appear
module alu_lcd_formatter #(
  parameter int DEB_CYCLES = 1000000
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic       iKEY_N,
  input  logic [3:0] iA,
  input  logic [3:0] iB,
  input  logic [1:0] iSEL,
  input  logic [3:0] iRES,
  output logic [7:0] d0x0,
  output logic [7:0] d0x1,
  output logic [7:0] d0x2,
  output logic [7:0] d0x3,
  output logic [7:0] d0x4,
  output logic [7:0] d0x5,
  output logic [7:0] d1x0,
  output logic [7:0] d1x1,
  output logic [7:0] d1x2,
  output logic [7:0] d1x3,
  output logic [7:0] d1x4,
  output logic [7:0] d1x5,
  output logic       oBUSY,
  output logic       oDONE
);

  localparam int                 CNT_W   = $clog2(DEB_CYCLES);
  localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(DEB_CYCLES - 1);
  localparam logic [7:0]         CH_SP   = 8'h20;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CAPTURE = 3'd1,
    CONV_A  = 3'd2,
    CONV_B  = 3'd3,
    CONV_R  = 3'd4,
    WRITE   = 3'd5
  } state_t;

  // ---------------------------------------------------------------------------
  // Helper functions
  // ---------------------------------------------------------------------------
  // One double-dabble iteration on {tens, units, binary}: correct the units
  // digit, then shift the whole word left. Tens never exceeds 1 for a 4-bit
  // input, so it needs no correction.
  function automatic logic [11:0] dabble_step(input logic [11:0] x);
    logic [3:0] units;
    units = x[7:4];
    if (units >= 4'd5) units = units + 4'd3;
    return {x[10:8], units, x[3:0], 1'b0};
  endfunction

  function automatic logic [7:0] digit_char(input logic [3:0] d);
    return 8'h30 + {4'h0, d};
  endfunction

  function automatic logic [7:0] op_char(input logic [1:0] op);
    logic [7:0] c;
    case (op)
      2'b00:   c = 8'h2B;  // '+'
      2'b01:   c = 8'h2D;  // '-'
      2'b10:   c = 8'h26;  // '&'
      default: c = 8'h7C;  // '|'
    endcase
    return c;
  endfunction

  // ---------------------------------------------------------------------------
  // Key synchroniser and debouncer
  // ---------------------------------------------------------------------------
  logic             key_s1_q, key_s2_q;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] deb_cnt_q, deb_cnt_d;
  logic             press;

  always_comb begin
    deb_cnt_d = '0;
    stable_d  = stable_q;
    press     = 1'b0;
    if (key_s2_q != stable_q) begin
      if (deb_cnt_q == CNT_MAX) begin
        stable_d = key_s2_q;
        // Only the 1->0 transition of the accepted level is a press.
        press    = stable_q;
      end else begin
        deb_cnt_d = deb_cnt_q + CNT_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  state_t     state_q, state_d;
  logic [1:0] conv_cnt_q, conv_cnt_d;
  logic       busy, write_en, conv_active, last_step;

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      key_s1_q   <= 1'b1;
      key_s2_q   <= 1'b1;
      stable_q   <= 1'b1;
      deb_cnt_q  <= '0;
      state_q    <= IDLE;
      conv_cnt_q <= '0;
      oDONE      <= 1'b0;
    end else begin
      key_s1_q   <= iKEY_N;
      key_s2_q   <= key_s1_q;
      stable_q   <= stable_d;
      deb_cnt_q  <= deb_cnt_d;
      state_q    <= state_d;
      conv_cnt_q <= conv_cnt_d;
      // Registered so the pulse coincides with the new characters.
      oDONE      <= write_en;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (press) state_d = CAPTURE;
      CAPTURE: state_d = CONV_A;
      CONV_A:  if (last_step) state_d = CONV_B;
      CONV_B:  if (last_step) state_d = CONV_R;
      CONV_R:  if (last_step) state_d = WRITE;
      WRITE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy        = (state_q != IDLE);
    write_en    = (state_q == WRITE);
    conv_active = (state_q == CONV_A) || (state_q == CONV_B) ||
                  (state_q == CONV_R);
    last_step   = conv_active && (conv_cnt_q == 2'd3);
    // Free-running 2-bit step counter; wraps to 0 on the fourth step.
    conv_cnt_d  = conv_active ? conv_cnt_q + 2'd1 : 2'd0;
  end

  assign oBUSY = busy;

  // ---------------------------------------------------------------------------
  // Capture and conversion datapath
  // ---------------------------------------------------------------------------
  logic [3:0]  b_q, res_q;
  logic [1:0]  sel_q;
  logic [11:0] dd_q, dd_d, dd_step;
  logic [7:0]  a_bcd_q, b_bcd_q, r_bcd_q;
  logic [3:0]  res_mag;
  logic        res_neg;

`ifdef SIGNED_RES_EN
  assign res_neg = (sel_q == 2'b01) && res_q[3];
  assign res_mag = res_neg ? (~res_q + 4'd1) : res_q;
`else
  assign res_neg = 1'b0;
  assign res_mag = res_q;
`endif

  assign dd_step = dabble_step(dd_q);

  // The next value to convert is loaded on the final step of the previous one,
  // so the three conversions run back to back.
  always_comb begin
    dd_d = dd_q;
    if (state_q == CAPTURE) begin
      dd_d = {8'h00, iA};
    end else if (conv_active) begin
      dd_d = dd_step;
      if (last_step) begin
        if (state_q == CONV_A)      dd_d = {8'h00, b_q};
        else if (state_q == CONV_B) dd_d = {8'h00, res_mag};
      end
    end
  end

  always_ff @(posedge iCLK) begin
    dd_q <= dd_d;
    if (state_q == CAPTURE) begin
      b_q   <= iB;
      sel_q <= iSEL;
      res_q <= iRES;
    end
    if (last_step) begin
      if (state_q == CONV_A) a_bcd_q <= dd_step[11:4];
      if (state_q == CONV_B) b_bcd_q <= dd_step[11:4];
      if (state_q == CONV_R) r_bcd_q <= dd_step[11:4];
    end
  end

  // ---------------------------------------------------------------------------
  // Character output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      d0x0 <= CH_SP;
      d0x1 <= CH_SP;
      d0x2 <= CH_SP;
      d0x3 <= CH_SP;
      d0x4 <= CH_SP;
      d0x5 <= CH_SP;
      d1x0 <= CH_SP;
      d1x1 <= CH_SP;
      d1x2 <= CH_SP;
      d1x3 <= CH_SP;
      d1x4 <= CH_SP;
      d1x5 <= CH_SP;
    end else if (write_en) begin
      d0x0 <= digit_char(a_bcd_q[7:4]);
      d0x1 <= digit_char(a_bcd_q[3:0]);
      d0x2 <= op_char(sel_q);
      d0x3 <= digit_char(b_bcd_q[7:4]);
      d0x4 <= digit_char(b_bcd_q[3:0]);
      d0x5 <= 8'h3D;  // '='
      d1x0 <= 8'h52;  // 'R'
      d1x1 <= 8'h3D;  // '='
      d1x2 <= res_neg ? 8'h2D : CH_SP;
      d1x3 <= digit_char(r_bcd_q[7:4]);
      d1x4 <= digit_char(r_bcd_q[3:0]);
      d1x5 <= CH_SP;
    end
  end

endmodule
